// File: rtl/wall_collision_scanner.sv
// Snapshots wall and player positions on start, then tests one wall per
// clock for bounding-box overlap and publishes hit, lowest index and mask.
module wall_collision_scanner #(
    parameter int WALL_NUM = 10,
    parameter int COORD_W  = 11,
    parameter int WALL_W   = 32,
    parameter int WALL_H   = 32,
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 16,
    parameter int IDX_W    = 4
) (
    input  logic                        pixel_clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WALL_NUM*COORD_W-1:0] wall_x_flat,
    input  logic [WALL_NUM*COORD_W-1:0] wall_y_flat,
    input  logic [WALL_NUM-1:0]         wall_valid,
    input  logic [COORD_W-1:0]          player_x,
    input  logic [COORD_W-1:0]          player_y,
    output logic                        busy,
    output logic                        done,
    output logic                        hit,
    output logic [IDX_W-1:0]            hit_index,
    output logic [WALL_NUM-1:0]         hit_mask
);

    localparam int EXT_W  = COORD_W + 1;
    localparam int FLAT_W = WALL_NUM * COORD_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WALL_NUM - 1);

    localparam logic [EXT_W-1:0] WALL_W_E   = EXT_W'(WALL_W);
    localparam logic [EXT_W-1:0] WALL_H_E   = EXT_W'(WALL_H);
    localparam logic [EXT_W-1:0] PLAYER_W_E = EXT_W'(PLAYER_W);
    localparam logic [EXT_W-1:0] PLAYER_H_E = EXT_W'(PLAYER_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WALL_NUM-1:0] mask_q, mask_d;

    logic [FLAT_W-1:0]   wx_q, wx_d;
    logic [FLAT_W-1:0]   wy_q, wy_d;
    logic [WALL_NUM-1:0] valid_q, valid_d;
    logic [COORD_W-1:0]  px_q, px_d;
    logic [COORD_W-1:0]  py_q, py_d;

    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    hit_index_q, hit_index_d;
    logic [WALL_NUM-1:0] hit_mask_q, hit_mask_d;

    logic [COORD_W-1:0] cur_wx;
    logic [COORD_W-1:0] cur_wy;
    logic               cur_valid;

    logic [EXT_W-1:0] wx_e;
    logic [EXT_W-1:0] wy_e;
    logic [EXT_W-1:0] px_e;
    logic [EXT_W-1:0] py_e;
    logic             overlap;

    function automatic logic [IDX_W-1:0] lowest_set(
        input logic [WALL_NUM-1:0] m
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = WALL_NUM - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = IDX_W'(k);
            end
        end
        return r;
    endfunction

    // Select the snapshot entry for the wall under test.
    always_comb begin
        cur_wx    = '0;
        cur_wy    = '0;
        cur_valid = 1'b0;
        for (int k = 0; k < WALL_NUM; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_wx    = wx_q[k*COORD_W +: COORD_W];
                cur_wy    = wy_q[k*COORD_W +: COORD_W];
                cur_valid = valid_q[k];
            end
        end
    end

    // One extra bit keeps every sum from wrapping; strict compares
    // make touching edges a miss.
    always_comb begin
        wx_e = EXT_W'(cur_wx);
        wy_e = EXT_W'(cur_wy);
        px_e = EXT_W'(px_q);
        py_e = EXT_W'(py_q);
        overlap = cur_valid
               && (px_e < wx_e + WALL_W_E)
               && (wx_e < px_e + PLAYER_W_E)
               && (py_e < wy_e + WALL_H_E)
               && (wy_e < py_e + PLAYER_H_E);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        wx_d        = wx_q;
        wy_d        = wy_q;
        valid_d     = valid_q;
        px_d        = px_q;
        py_d        = py_q;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        hit_mask_d  = hit_mask_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    mask_d  = '0;
                    wx_d    = wall_x_flat;
                    wy_d    = wall_y_flat;
                    valid_d = wall_valid;
                    px_d    = player_x;
                    py_d    = player_y;
                end
            end
            SCAN: begin
                mask_d = mask_q | (WALL_NUM'(overlap) << idx_q);
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    hit_mask_d  = mask_d;
                    hit_d       = |mask_d;
                    hit_index_d = lowest_set(mask_d);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            wx_q        <= '0;
            wy_q        <= '0;
            valid_q     <= '0;
            px_q        <= '0;
            py_q        <= '0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
            hit_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            valid_q     <= valid_d;
            px_q        <= px_d;
            py_q        <= py_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
            hit_mask_q  <= hit_mask_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign hit       = hit_q;
    assign hit_index = hit_index_q;
    assign hit_mask  = hit_mask_q;

endmodule

// File: tb/tb_wall_collision_scanner.sv
// Scoreboard bench for wall_collision_scanner at default parameters.
module tb_wall_collision_scanner;

    localparam int WALL_NUM = 10;
    localparam int COORD_W  = 11;
    localparam int IDX_W    = 4;

    logic                        pixel_clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        start = 1'b0;
    logic [WALL_NUM*COORD_W-1:0] wall_x_flat = '0;
    logic [WALL_NUM*COORD_W-1:0] wall_y_flat = '0;
    logic [WALL_NUM-1:0]         wall_valid = '0;
    logic [COORD_W-1:0]          player_x = '0;
    logic [COORD_W-1:0]          player_y = '0;
    logic                        busy;
    logic                        done;
    logic                        hit;
    logic [IDX_W-1:0]            hit_index;
    logic [WALL_NUM-1:0]         hit_mask;

    wall_collision_scanner dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .start       (start),
        .wall_x_flat (wall_x_flat),
        .wall_y_flat (wall_y_flat),
        .wall_valid  (wall_valid),
        .player_x    (player_x),
        .player_y    (player_y),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .hit_index   (hit_index),
        .hit_mask    (hit_mask)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic                hit;
        logic [IDX_W-1:0]    idx;
        logic [WALL_NUM-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   start_cyc = 0;

    task automatic set_wall(input int k, input int x, input int y);
        wall_x_flat[k*COORD_W +: COORD_W] = COORD_W'(x);
        wall_y_flat[k*COORD_W +: COORD_W] = COORD_W'(y);
    endtask

    task automatic set_default();
        for (int k = 0; k < WALL_NUM; k++) set_wall(k, k * 50, 0);
        wall_valid = '1;
        player_x   = 11'd400;
        player_y   = 11'd400;
    endtask

    task automatic kick(input bit push, input bit h, input int ix,
                        input int m);
        exp_t e;
        @(negedge pixel_clk);
        start = 1'b1;
        @(posedge pixel_clk);
        #1 start_cyc = cyc;
        if (push) begin
            e.hit  = h;
            e.idx  = IDX_W'(ix);
            e.mask = WALL_NUM'(m);
            exp_q.push_back(e);
        end
        @(negedge pixel_clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1)
            $display("FAIL kick_busy got %b want 1", busy);
        else passed++;
    endtask

    task automatic collect(input string name, input bit chk_lat,
                           output int done_at);
        bit   found;
        exp_t e;
        found   = 1'b0;
        done_at = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pixel_clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            $display("FAIL %s done_timeout got none want pulse", name);
            return;
        end
        done_at = cyc;
        if (chk_lat) begin
            total++;
            if (cyc - start_cyc !== 10)
                $display("FAIL %s latency got %0d want 10", name,
                         cyc - start_cyc);
            else passed++;
        end
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard got done want no done", name);
        end else begin
            passed++;
            e = exp_q.pop_front();
            total++;
            if (hit !== e.hit)
                $display("FAIL %s hit got %b want %b", name, hit, e.hit);
            else passed++;
            total++;
            if (hit_index !== e.idx)
                $display("FAIL %s hit_index got %0d want %0d", name,
                         hit_index, e.idx);
            else passed++;
            total++;
            if (hit_mask !== e.mask)
                $display("FAIL %s hit_mask got %h want %h", name,
                         hit_mask, e.mask);
            else passed++;
        end
        @(negedge pixel_clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done got done=%b busy=%b want 0 0",
                     name, done, busy);
        else passed++;
    endtask

    task automatic check_idle_zero(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL %s busy_done got %b %b want 0 0", name, busy, done);
        else passed++;
        total++;
        if (hit !== 1'b0 || hit_index !== '0 || hit_mask !== '0)
            $display("FAIL %s results got %b %0d %h want 0 0 0", name,
                     hit, hit_index, hit_mask);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge pixel_clk);
        reset = 1'b0;
        check_idle_zero("reset");
    endtask

    task automatic test_no_overlap();
        int d;
        set_default();
        kick(1'b1, 1'b0, 0, 0);
        collect("no_overlap", 1'b1, d);
    endtask

    task automatic test_single();
        int d;
        set_default();
        set_wall(3, 390, 390);
        kick(1'b1, 1'b1, 3, 'h008);
        collect("single", 1'b1, d);
    endtask

    task automatic test_boundary();
        int d;
        set_default();
        set_wall(0, 368, 400);
        kick(1'b1, 1'b0, 0, 0);
        collect("touch_edge", 1'b1, d);
        set_wall(0, 369, 400);
        kick(1'b1, 1'b1, 0, 'h001);
        collect("one_px_in", 1'b1, d);
        set_wall(0, 2047, 2047);
        player_x = 11'd2040;
        player_y = 11'd2040;
        kick(1'b1, 1'b1, 0, 'h001);
        collect("no_wrap", 1'b1, d);
    endtask

    task automatic test_multi();
        int d;
        set_default();
        set_wall(2, 400, 400);
        set_wall(7, 400, 400);
        kick(1'b1, 1'b1, 2, 'h084);
        collect("multi", 1'b1, d);
        wall_valid[2] = 1'b0;
        kick(1'b1, 1'b1, 7, 'h080);
        collect("masked", 1'b1, d);
    endtask

    task automatic test_snapshot();
        int d;
        set_default();
        set_wall(3, 390, 390);
        kick(1'b1, 1'b1, 3, 'h008);
        repeat (2) @(negedge pixel_clk);
        set_wall(3, 0, 0);
        set_wall(5, 400, 400);
        wall_valid = '0;
        player_x   = 11'd0;
        collect("snapshot", 1'b1, d);
    endtask

    task automatic test_reset_mid();
        int d;
        int seen;
        set_default();
        set_wall(5, 400, 400);
        kick(1'b1, 1'b1, 5, 'h020);
        collect("pre_reset", 1'b1, d);
        kick(1'b0, 1'b0, 0, 0);
        repeat (4) @(negedge pixel_clk);
        reset = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b0;
        check_idle_zero("reset_mid");
        seen = 0;
        repeat (20) begin
            @(negedge pixel_clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL reset_mid_no_done got %0d want 0", seen);
        else passed++;
        kick(1'b1, 1'b1, 5, 'h020);
        collect("rearm", 1'b1, d);
    endtask

    task automatic test_reset_start();
        @(negedge pixel_clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle_zero("reset_with_start");
        @(negedge pixel_clk);
        total++;
        if (busy !== 1'b0)
            $display("FAIL reset_start_busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int d0, d1, d2;
        exp_t e;
        set_default();
        set_wall(2, 410, 395);
        e.hit  = 1'b1;
        e.idx  = 4'd2;
        e.mask = 10'h004;
        repeat (3) exp_q.push_back(e);
        @(negedge pixel_clk);
        start = 1'b1;
        @(posedge pixel_clk);
        #1 start_cyc = cyc;
        collect("b2b_0", 1'b1, d0);
        collect("b2b_1", 1'b0, d1);
        collect("b2b_2", 1'b0, d2);
        start = 1'b0;
        total++;
        if (d1 - d0 !== 12)
            $display("FAIL b2b_period1 got %0d want 12", d1 - d0);
        else passed++;
        total++;
        if (d2 - d1 !== 12)
            $display("FAIL b2b_period2 got %0d want 12", d2 - d1);
        else passed++;
        repeat (2) @(negedge pixel_clk);
        total++;
        if (busy !== 1'b0)
            $display("FAIL b2b_stop got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_ignored_start();
        int d;
        int seen;
        set_default();
        set_wall(7, 395, 410);
        kick(1'b1, 1'b1, 7, 'h080);
        repeat (2) @(negedge pixel_clk);
        start = 1'b1;
        @(negedge pixel_clk);
        start = 1'b0;
        repeat (3) @(negedge pixel_clk);
        start = 1'b1;
        @(negedge pixel_clk);
        start = 1'b0;
        collect("ignored_start", 1'b1, d);
        seen = 0;
        repeat (15) begin
            @(negedge pixel_clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL ignored_start_queued got %0d want 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_no_overlap();
        test_single();
        test_boundary();
        test_multi();
        test_snapshot();
        test_reset_mid();
        test_reset_start();
        test_back_to_back();
        test_ignored_start();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
